// File: rtl/wave_pkg.sv
// Shared definitions for the 5-bit waveform generator / classifier pair.
// Wave type codes match the generator's select input.
package wave_pkg;

  localparam int SAMPLE_W = 5;

  typedef enum logic [1:0] {
    WAVE_SQUARE  = 2'b00,
    WAVE_SAW     = 2'b01,
    WAVE_TRI     = 2'b10,
    WAVE_UNKNOWN = 2'b11
  } wave_type_e;

  typedef enum logic [1:0] {
    ST_PRIME   = 2'b00,
    ST_ACQUIRE = 2'b01,
    ST_REPORT  = 2'b10
  } cls_state_e;

  // Sticky slope observations collected over one window.
  typedef struct packed {
    logic up1;
    logic dn1;
    logic bigup;
    logic bigdn;
  } slope_flags_t;

  // Signed sample-to-sample difference; 6 bits cover -31..+31.
  function automatic logic signed [SAMPLE_W:0] sample_delta(
    input logic [SAMPLE_W-1:0] cur,
    input logic [SAMPLE_W-1:0] prev
  );
    sample_delta = $signed({1'b0, cur}) - $signed({1'b0, prev});
  endfunction

  // The three shape rules are mutually exclusive; anything else is unknown.
  function automatic wave_type_e classify(input slope_flags_t f);
    case ({f.bigup, f.bigdn, f.up1, f.dn1})
      4'b1100: classify = WAVE_SQUARE;
      4'b0110: classify = WAVE_SAW;
      4'b0011: classify = WAVE_TRI;
      default: classify = WAVE_UNKNOWN;
    endcase
  endfunction

endpackage

// File: rtl/wave_classifier_if.sv
// Sample stream in, per-window classification results out.
// master: the sample source / result consumer; slave: the classifier.
interface wave_classifier_if import wave_pkg::*; #(
  parameter int PW = 8
);
  logic                in_valid;
  logic [SAMPLE_W-1:0] wave_in;
  logic                result_valid;
  logic [1:0]          wave_type;
  logic [PW-1:0]       period;
  logic [SAMPLE_W-1:0] peak;
  logic [SAMPLE_W-1:0] trough;

  modport master (
    output in_valid, wave_in,
    input  result_valid, wave_type, period, peak, trough
  );

  modport slave (
    input  in_valid, wave_in,
    output result_valid, wave_type, period, peak, trough
  );
endinterface

// File: rtl/wave_period_meter.sv
// Fundamental-period measurement: counts valid samples between rising-edge
// anchors (first positive delta after a non-positive one). Runs across
// classification windows; only rst clears its history.
module wave_period_meter #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sample_valid,
  input  logic          delta_neg,
  input  logic          delta_zero,
  output logic [PW-1:0] last_period,
  output logic [PW-1:0] last_period_nxt
);

  localparam logic [PW-1:0] PCNT_MAX = {PW{1'b1}};

  logic          rising_r;
  logic          anchored_r;
  logic [PW-1:0] pcnt_r;
  logic [PW-1:0] last_period_r;

  logic          rising_nxt_s;
  logic          anchored_nxt_s;
  logic [PW-1:0] pcnt_nxt_s;
  logic [PW-1:0] lp_nxt_s;
  logic          delta_pos_s;
  logic          anchor_s;

  assign delta_pos_s = !delta_neg && !delta_zero;
  assign anchor_s    = sample_valid && delta_pos_s && !rising_r;

  // Next-state of the meter; an anchor takes priority over saturation.
  always_comb begin
    rising_nxt_s   = rising_r;
    anchored_nxt_s = anchored_r;
    pcnt_nxt_s     = pcnt_r;
    lp_nxt_s       = last_period_r;
    if (sample_valid) begin
      rising_nxt_s = delta_pos_s;
      if (anchor_s) begin
        pcnt_nxt_s     = {{(PW-1){1'b0}}, 1'b1};
        anchored_nxt_s = 1'b1;
        if (anchored_r) begin
          lp_nxt_s = pcnt_r;
        end else begin
          lp_nxt_s = last_period_r;
        end
      end else if (pcnt_r == PCNT_MAX) begin
        pcnt_nxt_s = pcnt_r;
        lp_nxt_s   = '0;
      end else begin
        pcnt_nxt_s = pcnt_r + {{(PW-1){1'b0}}, 1'b1};
        if (pcnt_r == (PCNT_MAX - {{(PW-1){1'b0}}, 1'b1})) begin
          lp_nxt_s = '0;
        end else begin
          lp_nxt_s = last_period_r;
        end
      end
    end else begin
      rising_nxt_s   = rising_r;
      anchored_nxt_s = anchored_r;
      pcnt_nxt_s     = pcnt_r;
      lp_nxt_s       = last_period_r;
    end
  end

  // Meter state registers; direction starts as non-rising.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rising_r      <= 1'b0;
      anchored_r    <= 1'b0;
      pcnt_r        <= '0;
      last_period_r <= '0;
    end else begin
      rising_r      <= rising_nxt_s;
      anchored_r    <= anchored_nxt_s;
      pcnt_r        <= pcnt_nxt_s;
      last_period_r <= lp_nxt_s;
    end
  end

  assign last_period     = last_period_r;
  assign last_period_nxt = lp_nxt_s;

endmodule

// File: rtl/wave_classifier.sv
// Windowed waveform classifier for a 5-bit sample stream. Each window of
// WINDOW deltas is classified as square / sawtooth / triangle / unknown,
// with peak, trough and the running fundamental period.
module wave_classifier import wave_pkg::*; #(
  parameter int WINDOW = 128,
  parameter int PW     = 8
) (
  input  logic               clk,
  input  logic               rst,
  wave_classifier_if.slave   bus
);

  localparam int CW = $clog2(WINDOW + 1);
  localparam logic signed [SAMPLE_W:0] D_UP1 = 6'sd1;
  localparam logic signed [SAMPLE_W:0] D_DN1 = -6'sd1;

  cls_state_e          state_r;
  logic [SAMPLE_W-1:0] prev_r;
  logic [CW-1:0]       cnt_r;
  slope_flags_t        flags_r;
  logic [SAMPLE_W-1:0] max_r;
  logic [SAMPLE_W-1:0] min_r;

  logic                result_valid_r;
  wave_type_e          wave_type_r;
  logic [PW-1:0]       period_r;
  logic [SAMPLE_W-1:0] peak_r;
  logic [SAMPLE_W-1:0] trough_r;

  logic signed [SAMPLE_W:0] delta_s;
  logic                sample_s;
  logic                close_s;
  slope_flags_t        base_flags_s;
  logic [CW-1:0]       base_cnt_s;
  logic [SAMPLE_W-1:0] base_max_s;
  logic [SAMPLE_W-1:0] base_min_s;
  slope_flags_t        flags_nxt_s;
  logic [CW-1:0]       cnt_nxt_s;
  logic [SAMPLE_W-1:0] max_nxt_s;
  logic [SAMPLE_W-1:0] min_nxt_s;
  logic [PW-1:0]       last_period_s;
  logic [PW-1:0]       last_period_nxt_s;

  assign delta_s  = sample_delta(bus.wave_in, prev_r);
  // Both ACQUIRE and REPORT take samples; REPORT feeds them into the new window.
  assign sample_s = bus.in_valid && (state_r != ST_PRIME);
  assign close_s  = (state_r == ST_ACQUIRE) && sample_s && (cnt_nxt_s == CW'(WINDOW));

  wave_period_meter #(.PW(PW)) u_period (
    .clk             (clk),
    .rst             (rst),
    .sample_valid    (sample_s),
    .delta_neg       (delta_s[SAMPLE_W]),
    .delta_zero      (delta_s == 6'sd0),
    .last_period     (last_period_s),
    .last_period_nxt (last_period_nxt_s)
  );

  // Window starting point: REPORT restarts from the retained prev sample.
  always_comb begin
    base_flags_s = flags_r;
    base_cnt_s   = cnt_r;
    base_max_s   = max_r;
    base_min_s   = min_r;
    if (state_r == ST_REPORT) begin
      base_flags_s = '0;
      base_cnt_s   = '0;
      base_max_s   = prev_r;
      base_min_s   = prev_r;
    end else begin
      base_flags_s = flags_r;
      base_cnt_s   = cnt_r;
      base_max_s   = max_r;
      base_min_s   = min_r;
    end
  end

  // Fold the current valid sample into flags, delta count and extremes.
  always_comb begin
    flags_nxt_s = base_flags_s;
    cnt_nxt_s   = base_cnt_s;
    max_nxt_s   = base_max_s;
    min_nxt_s   = base_min_s;
    if (sample_s) begin
      cnt_nxt_s = base_cnt_s + {{(CW-1){1'b0}}, 1'b1};
      if (delta_s == D_UP1) begin
        flags_nxt_s.up1 = 1'b1;
      end else if (delta_s == D_DN1) begin
        flags_nxt_s.dn1 = 1'b1;
      end else if (delta_s > D_UP1) begin
        flags_nxt_s.bigup = 1'b1;
      end else if (delta_s < D_DN1) begin
        flags_nxt_s.bigdn = 1'b1;
      end else begin
        flags_nxt_s = base_flags_s;
      end
      if (bus.wave_in > base_max_s) begin
        max_nxt_s = bus.wave_in;
      end else begin
        max_nxt_s = base_max_s;
      end
      if (bus.wave_in < base_min_s) begin
        min_nxt_s = bus.wave_in;
      end else begin
        min_nxt_s = base_min_s;
      end
    end else begin
      flags_nxt_s = base_flags_s;
      cnt_nxt_s   = base_cnt_s;
      max_nxt_s   = base_max_s;
      min_nxt_s   = base_min_s;
    end
  end

  // Control FSM and result registers. Results are captured from the
  // next-state view on the closing edge so they are visible during REPORT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= ST_PRIME;
      prev_r         <= '0;
      cnt_r          <= '0;
      flags_r        <= '0;
      max_r          <= '0;
      min_r          <= '0;
      result_valid_r <= 1'b0;
      wave_type_r    <= WAVE_UNKNOWN;
      period_r       <= '0;
      peak_r         <= '0;
      trough_r       <= '0;
    end else begin
      case (state_r)
        ST_PRIME: begin
          result_valid_r <= 1'b0;
          if (bus.in_valid) begin
            prev_r  <= bus.wave_in;
            max_r   <= bus.wave_in;
            min_r   <= bus.wave_in;
            flags_r <= '0;
            cnt_r   <= '0;
            state_r <= ST_ACQUIRE;
          end else begin
            state_r <= ST_PRIME;
          end
        end
        ST_ACQUIRE, ST_REPORT: begin
          flags_r <= flags_nxt_s;
          cnt_r   <= cnt_nxt_s;
          max_r   <= max_nxt_s;
          min_r   <= min_nxt_s;
          if (sample_s) begin
            prev_r <= bus.wave_in;
          end else begin
            prev_r <= prev_r;
          end
          if (close_s) begin
            state_r        <= ST_REPORT;
            result_valid_r <= 1'b1;
            wave_type_r    <= classify(flags_nxt_s);
            period_r       <= last_period_nxt_s;
            peak_r         <= max_nxt_s;
            trough_r       <= min_nxt_s;
          end else begin
            state_r        <= ST_ACQUIRE;
            result_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r        <= ST_PRIME;
          result_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.result_valid = result_valid_r;
  assign bus.wave_type    = wave_type_r;
  assign bus.period       = period_r;
  assign bus.peak         = peak_r;
  assign bus.trough       = trough_r;

endmodule

// File: tb/tb_wave_classifier.sv
// Self-checking bench for wave_classifier. A reference model keeps the full
// history of accepted samples and derives each window's results from it.
module tb_wave_classifier;
  import wave_pkg::*;

  localparam int W    = 128;
  localparam int PW   = 8;
  localparam int PMAX = 255;
  localparam logic [20:0] RESET_V = {1'b0, 2'b11, 8'd0, 5'd0, 5'd0};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wave_classifier_if #(.PW(PW)) bus ();
  wave_classifier #(.WINDOW(W), .PW(PW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp  = 0;
  int n_fail = 0;
  int hist[$];
  logic [20:0] exp_v;
  logic [20:0] obs_v;

  function automatic logic [4:0] sq_val(int k);
    return ((k % 20) < 10) ? 5'd0 : 5'd20;
  endfunction
  function automatic logic [4:0] saw_val(int k);
    return 5'(k % 21);
  endfunction
  function automatic logic [4:0] tri_val(int k);
    int p;
    p = k % 40;
    return (p <= 20) ? 5'(p) : 5'(40 - p);
  endfunction

  // Shape of the window ending at sample n (deltas n-W+1 .. n).
  function automatic logic [1:0] ref_type(int n);
    bit up1 = 0, dn1 = 0, bu = 0, bd = 0;
    for (int i = n - W + 1; i <= n; i++) begin
      int d;
      d = hist[i] - hist[i-1];
      if (d == 1) up1 = 1;
      else if (d == -1) dn1 = 1;
      else if (d >= 2) bu = 1;
      else if (d <= -2) bd = 1;
    end
    if (bu && bd && !up1 && !dn1) return 2'b00;
    if (up1 && bd && !dn1 && !bu) return 2'b01;
    if (up1 && dn1 && !bu && !bd) return 2'b10;
    return 2'b11;
  endfunction

  // Period: distance between the last two anchors, zero once the counter
  // since the last anchor has run out of range.
  function automatic logic [7:0] ref_period(int n);
    int last = -1, prv = -1;
    bit rising = 0;
    for (int i = 1; i <= n; i++) begin
      int d;
      d = hist[i] - hist[i-1];
      if (d > 0 && !rising) begin
        prv  = last;
        last = i;
      end
      rising = (d > 0);
    end
    if (last < 0) return 8'd0;
    if (n - last >= PMAX - 1) return 8'd0;
    if (prv < 0) return 8'd0;
    if (last - prv >= PMAX) return 8'(PMAX);
    return 8'(last - prv);
  endfunction

  function automatic logic [4:0] ref_peak(int n);
    int m = 0;
    for (int i = n - W; i <= n; i++) if (hist[i] > m) m = hist[i];
    return 5'(m);
  endfunction
  function automatic logic [4:0] ref_trough(int n);
    int m = 31;
    for (int i = n - W; i <= n; i++) if (hist[i] < m) m = hist[i];
    return 5'(m);
  endfunction

  // One clock of stimulus; updates the model expectation and samples the DUT.
  task automatic tick(input bit v, input logic [4:0] x);
    int n;
    bus.in_valid = v;
    bus.wave_in  = x;
    @(posedge clk);
    exp_v[20] = 1'b0;
    if (v) begin
      hist.push_back(int'(x));
      n = hist.size() - 1;
      if (n > 0 && (n % W) == 0)
        exp_v = {1'b1, ref_type(n), ref_period(n), ref_peak(n), ref_trough(n)};
    end
    @(negedge clk);
    obs_v = {bus.result_valid, bus.wave_type, bus.period, bus.peak, bus.trough};
  endtask

  task automatic apply_reset();
    #2 rst = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    hist.delete();
    exp_v = RESET_V;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 1'b1;
      bus.wave_in  = 5'($urandom_range(0, 31));
      @(negedge clk);
      obs_v = {bus.result_valid, bus.wave_type, bus.period, bus.peak, bus.trough};
      n_cmp++;
      if (obs_v !== RESET_V) begin
        n_fail++;
        $display("FAIL reset k=%0d got=%h expected=%h", k, obs_v, RESET_V);
      end
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    hist.delete();
    exp_v = RESET_V;
  endtask

  task automatic test_square();
    int ph;
    ph = $urandom_range(0, 19);
    apply_reset();
    for (int k = 0; k < 3 * W + 1; k++) begin
      tick(1'b1, sq_val(k + ph));
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL square k=%0d got=%h expected=%h", k, obs_v, exp_v);
      end
    end
    n_cmp++;
    if (obs_v[19:0] !== {2'b00, 8'd20, 5'd20, 5'd0}) begin
      n_fail++;
      $display("FAIL square_final got=%h expected=%h", obs_v[19:0], {2'b00, 8'd20, 5'd20, 5'd0});
    end
  endtask

  task automatic test_sawtooth();
    int ph;
    ph = $urandom_range(0, 20);
    apply_reset();
    for (int k = 0; k < 3 * W + 1; k++) begin
      tick(1'b1, saw_val(k + ph));
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL saw k=%0d got=%h expected=%h", k, obs_v, exp_v);
      end
    end
    n_cmp++;
    if (obs_v[19:0] !== {2'b01, 8'd21, 5'd20, 5'd0}) begin
      n_fail++;
      $display("FAIL saw_final got=%h expected=%h", obs_v[19:0], {2'b01, 8'd21, 5'd20, 5'd0});
    end
  endtask

  task automatic test_triangle();
    int first;
    first = -1;
    apply_reset();
    for (int k = 0; k < 3 * W + 1; k++) begin
      tick(1'b1, tri_val(k));
      if (obs_v[20] && first < 0) first = k;
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL tri k=%0d got=%h expected=%h", k, obs_v, exp_v);
      end
    end
    n_cmp++;
    if (first != W) begin
      n_fail++;
      $display("FAIL tri_first_pulse got=%0d expected=%0d", first, W);
    end
    n_cmp++;
    if (obs_v[19:0] !== {2'b10, 8'd40, 5'd20, 5'd0}) begin
      n_fail++;
      $display("FAIL tri_final got=%h expected=%h", obs_v[19:0], {2'b10, 8'd40, 5'd20, 5'd0});
    end
  endtask

  task automatic test_constant();
    apply_reset();
    for (int k = 0; k < 3 * W + 1; k++) begin
      tick(1'b1, 5'd7);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL const k=%0d got=%h expected=%h", k, obs_v, exp_v);
      end
    end
    n_cmp++;
    if (obs_v[19:0] !== {2'b11, 8'd0, 5'd7, 5'd7}) begin
      n_fail++;
      $display("FAIL const_final got=%h expected=%h", obs_v[19:0], {2'b11, 8'd0, 5'd7, 5'd7});
    end
  endtask

  task automatic test_gapped();
    int first, idx;
    first = -1;
    idx   = 0;
    apply_reset();
    for (int k = 0; k < 2 * (2 * W + 1); k++) begin
      if ((k % 2) == 0) begin
        tick(1'b1, tri_val(idx));
        idx++;
      end else begin
        tick(1'b0, 5'($urandom_range(0, 31)));
      end
      if (obs_v[20] && first < 0) first = k;
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL gapped k=%0d got=%h expected=%h", k, obs_v, exp_v);
      end
    end
    n_cmp++;
    if (first != 2 * W) begin
      n_fail++;
      $display("FAIL gapped_first_pulse got=%0d expected=%0d", first, 2 * W);
    end
    n_cmp++;
    if (obs_v[19:0] !== {2'b10, 8'd40, 5'd20, 5'd0}) begin
      n_fail++;
      $display("FAIL gapped_final got=%h expected=%h", obs_v[19:0], {2'b10, 8'd40, 5'd20, 5'd0});
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int k = 0; k < 600; k++) begin
      tick($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)));
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL random k=%0d got=%h expected=%h", k, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int k = 0; k < W + 1 + 50; k++) begin
      tick(1'b1, saw_val(k));
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL mid_saw k=%0d got=%h expected=%h", k, obs_v, exp_v);
      end
    end
    #2 rst = 1'b1;
    #1;
    obs_v = {bus.result_valid, bus.wave_type, bus.period, bus.peak, bus.trough};
    n_cmp++;
    if (obs_v !== RESET_V) begin
      n_fail++;
      $display("FAIL mid_async_reset got=%h expected=%h", obs_v, RESET_V);
    end
    hist.delete();
    exp_v = RESET_V;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2 * W + 1; k++) begin
      tick(1'b1, sq_val(k));
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL mid_square k=%0d got=%h expected=%h", k, obs_v, exp_v);
      end
    end
    n_cmp++;
    if (obs_v[19:0] !== {2'b00, 8'd20, 5'd20, 5'd0}) begin
      n_fail++;
      $display("FAIL mid_final got=%h expected=%h", obs_v[19:0], {2'b00, 8'd20, 5'd20, 5'd0});
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.wave_in  = 5'd0;
    exp_v        = RESET_V;
    obs_v        = RESET_V;
    test_reset();
    test_square();
    test_sawtooth();
    test_triangle();
    test_constant();
    test_gapped();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
